branch_resolve_predict: RTL and testbench

//  Parametrised branch unit: evaluates MIPS branch conditions in EX and adds a PC-indexed table of saturating counters.
//  IF reads a taken/not-taken prediction; EX resolves, trains the table, and raises a registered redirect on mispredict.
//  A one-cycle squash state blocks the wrong-path instruction in EX from training the table or redirecting again.

---
 rtl/branch_resolve_predict_pkg.sv | 14 +
 rtl/branch_resolve_predict_cond_eval.sv | 24 ++
 rtl/branch_resolve_predict.sv | 105 ++++++++++
 tb/tb_branch_resolve_predict.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_predict_pkg.sv
// Shared definitions for the branch unit: condition-select encodings and FSM state codes.
package branch_resolve_predict_pkg;

    localparam logic [2:0] BR_BEQ       = 3'd0;
    localparam logic [2:0] BR_BNE       = 3'd1;
    localparam logic [2:0] BR_BGTZ      = 3'd2;
    localparam logic [2:0] BR_BLEZ      = 3'd3;
    localparam logic [2:0] BR_BLTZ_BGEZ = 3'd4;

    // RUN resolves normally; SQUASH covers the single wrong-path instruction after a redirect
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

endpackage

// File: rtl/branch_resolve_predict_cond_eval.sv
// Combinational MIPS branch-condition evaluator: op/rt/zero/sign -> taken.
module branch_resolve_predict_cond_eval
    import branch_resolve_predict_pkg::*;
(
    input  logic [2:0] op,
    input  logic       rt,
    input  logic       zero,
    input  logic       sign_bit,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            BR_BEQ:       taken = zero;
            BR_BNE:       taken = ~zero;
            BR_BGTZ:      taken = ~zero & ~sign_bit;
            BR_BLEZ:      taken = zero | sign_bit;
            BR_BLTZ_BGEZ: taken = rt ? (zero | ~sign_bit) : (~zero & sign_bit);
            default:      taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_predict.sv
// Branch unit with a PC-indexed saturating-counter predictor, EX-stage resolution and registered redirect.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_predict
    import branch_resolve_predict_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_WIDTH = 2
`ifdef BRANCH_STATS_EN
    , parameter int STAT_WIDTH = 32
`endif
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [PC_WIDTH-1:0] If_PC,
    output logic                Pred_Taken,
    input  logic                Ex_Valid,
    input  logic                Ex_Branch,
    input  logic [PC_WIDTH-1:0] Ex_PC,
    input  logic [2:0]          Ex_BranchLogicOp,
    input  logic                Ex_Rt,
    input  logic                Ex_Zero,
    input  logic                Ex_SignBit,
    input  logic                Ex_PredTaken,
    input  logic [PC_WIDTH-1:0] Ex_Target,
    input  logic [PC_WIDTH-1:0] Ex_PCPlus4,
    output logic                Branch_out,
    output logic                Mispredict,
    output logic [PC_WIDTH-1:0] Redirect_PC,
    output logic                Dbg_State
`ifdef BRANCH_STATS_EN
    , output logic [STAT_WIDTH-1:0] Stat_Branches
    , output logic [STAT_WIDTH-1:0] Stat_Mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] bht [BHT_DEPTH];
    logic [0:0]           state;
    logic [IDX_W-1:0]     if_idx;
    logic [IDX_W-1:0]     ex_idx;
    logic                 cond_taken;
    logic                 live;
    logic                 mispred_d;
    logic                 unused_pc_bits;

    assign if_idx = If_PC[IDX_W+1:2];
    assign ex_idx = Ex_PC[IDX_W+1:2];
    assign unused_pc_bits = ^{If_PC[PC_WIDTH-1:IDX_W+2], If_PC[1:0],
                              Ex_PC[PC_WIDTH-1:IDX_W+2], Ex_PC[1:0]};

    branch_resolve_predict_cond_eval u_cond (
        .op       (Ex_BranchLogicOp),
        .rt       (Ex_Rt),
        .zero     (Ex_Zero),
        .sign_bit (Ex_SignBit),
        .taken    (cond_taken)
    );

    // Table read uses the pre-edge contents, so a same-cycle update is not forwarded to IF
    assign Pred_Taken = bht[if_idx][CNT_WIDTH-1];
    assign live       = Ex_Valid & Ex_Branch & (state == ST_RUN) & (Ex_BranchLogicOp <= BR_BLTZ_BGEZ);
    assign Branch_out = live & cond_taken;
    assign mispred_d  = live & (Branch_out != Ex_PredTaken);
    assign Dbg_State  = state[0];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= ST_RUN;
            Mispredict  <= 1'b0;
            Redirect_PC <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_INIT;
        end else begin
            Mispredict <= mispred_d;
            if (mispred_d) Redirect_PC <= Branch_out ? Ex_Target : Ex_PCPlus4;
            if (state == ST_SQUASH) state <= ST_RUN;
            else if (mispred_d)    state <= ST_SQUASH;
            if (live) begin
                if (Branch_out) begin
                    if (bht[ex_idx] != CNT_MAX) bht[ex_idx] <= bht[ex_idx] + 1'b1;
                end else begin
                    if (bht[ex_idx] != '0) bht[ex_idx] <= bht[ex_idx] - 1'b1;
                end
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Stat_Branches    <= '0;
            Stat_Mispredicts <= '0;
        end else begin
            if (live && Stat_Branches != {STAT_WIDTH{1'b1}})
                Stat_Branches <= Stat_Branches + 1'b1;
            if (mispred_d && Stat_Mispredicts != {STAT_WIDTH{1'b1}})
                Stat_Mispredicts <= Stat_Mispredicts + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench for branch_resolve_predict: resolution, table training, squash and reset behaviour.
module tb_branch_resolve_predict;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] If_PC;
    logic        Pred_Taken;
    logic        Ex_Valid, Ex_Branch;
    logic [31:0] Ex_PC;
    logic [2:0]  Ex_BranchLogicOp;
    logic        Ex_Rt, Ex_Zero, Ex_SignBit, Ex_PredTaken;
    logic [31:0] Ex_Target, Ex_PCPlus4;
    logic        Branch_out, Mispredict;
    logic [31:0] Redirect_PC;
    logic        Dbg_State;
`ifdef BRANCH_STATS_EN
    logic [31:0] Stat_Branches, Stat_Mispredicts;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    branch_resolve_predict dut (
        .Clk(Clk), .Rst_n(Rst_n), .If_PC(If_PC), .Pred_Taken(Pred_Taken),
        .Ex_Valid(Ex_Valid), .Ex_Branch(Ex_Branch), .Ex_PC(Ex_PC),
        .Ex_BranchLogicOp(Ex_BranchLogicOp), .Ex_Rt(Ex_Rt), .Ex_Zero(Ex_Zero),
        .Ex_SignBit(Ex_SignBit), .Ex_PredTaken(Ex_PredTaken), .Ex_Target(Ex_Target),
        .Ex_PCPlus4(Ex_PCPlus4), .Branch_out(Branch_out), .Mispredict(Mispredict),
        .Redirect_PC(Redirect_PC), .Dbg_State(Dbg_State)
`ifdef BRANCH_STATS_EN
        , .Stat_Branches(Stat_Branches), .Stat_Mispredicts(Stat_Mispredicts)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_idle();
        Ex_Valid = 1'b0; Ex_Branch = 1'b0; Ex_PC = '0; Ex_BranchLogicOp = '0;
        Ex_Rt = 1'b0; Ex_Zero = 1'b0; Ex_SignBit = 1'b0; Ex_PredTaken = 1'b0;
        Ex_Target = '0; Ex_PCPlus4 = 32'd4;
    endtask

    task automatic drive_br(input logic [31:0] pc, input logic [2:0] op, input logic rt,
                            input logic z, input logic s, input logic pred, input logic [31:0] tgt);
        Ex_Valid = 1'b1; Ex_Branch = 1'b1; Ex_PC = pc; Ex_BranchLogicOp = op;
        Ex_Rt = rt; Ex_Zero = z; Ex_SignBit = s; Ex_PredTaken = pred;
        Ex_Target = tgt; Ex_PCPlus4 = pc + 32'd4;
        #1;
    endtask

    // Checks a registered redirect against the oldest expected target
    task automatic check_redirect(input string tag);
        logic [31:0] e;
        check({tag, "_mp"}, {31'd0, Mispredict}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_q"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_pc"}, Redirect_PC, e);
        end
    endtask

    typedef struct packed {
        logic [2:0] op;
        logic rt, z, s, exp;
    } vec_t;

    vec_t vecs [6] = '{
        '{3'd2, 1'b0, 1'b0, 1'b0, 1'b1},
        '{3'd2, 1'b0, 1'b0, 1'b1, 1'b0},
        '{3'd3, 1'b0, 1'b1, 1'b0, 1'b1},
        '{3'd3, 1'b0, 1'b0, 1'b0, 1'b0},
        '{3'd1, 1'b0, 1'b1, 1'b0, 1'b0},
        '{3'd4, 1'b1, 1'b1, 1'b1, 1'b1}
    };

    initial begin
        Rst_n = 1'b0;
        If_PC = 32'h40;
        drive_idle();
        repeat (3) step();

        // Reset state
        check("rst_mp", {31'd0, Mispredict}, 32'd0);
        check("rst_rpc", Redirect_PC, 32'd0);
        check("rst_state", {31'd0, Dbg_State}, 32'd0);
        check("rst_pred", {31'd0, Pred_Taken}, 32'd0);
        check("rst_bht16", {30'd0, dut.bht[16]}, 32'd1);
        Rst_n = 1'b1;
        step();

        // BEQ taken while predicted not taken -> redirect to target
        drive_br(32'h40, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
        check("beq_br", {31'd0, Branch_out}, 32'd1);
        check("beq_mp_pre", {31'd0, Mispredict}, 32'd0);
        exp_q.push_back(32'h100);
        step();
        drive_idle();
        check_redirect("beq");
        check("beq_state", {31'd0, Dbg_State}, 32'd1);
        check("beq_bht16", {30'd0, dut.bht[16]}, 32'd2);
        check("beq_pred", {31'd0, Pred_Taken}, 32'd1);
        step();
        check("beq_mp_clr", {31'd0, Mispredict}, 32'd0);
        check("beq_state_run", {31'd0, Dbg_State}, 32'd0);
        check("beq_rpc_hold", Redirect_PC, 32'h100);

        // Saturation at PC 0x80 (index 32): 1 -> 2 (mispredict) -> 3 -> 3 -> 3
        If_PC = 32'h80;
        drive_br(32'h80, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h180);
        check("sat_rbw", {31'd0, Pred_Taken}, 32'd0);
        exp_q.push_back(32'h180);
        step();
        drive_idle();
        check_redirect("sat1");
        step();
        for (int i = 0; i < 3; i++) begin
            drive_br(32'h80, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h180);
            step();
            check("sat_nomp", {31'd0, Mispredict}, 32'd0);
        end
        check("sat_bht32", {30'd0, dut.bht[32]}, 32'd3);
        drive_br(32'h80, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h180);
        exp_q.push_back(32'h84);
        step();
        drive_idle();
        check_redirect("nt");
        check("nt_bht32", {30'd0, dut.bht[32]}, 32'd2);
        check("nt_pred", {31'd0, Pred_Taken}, 32'd1);
        step();

        // Squash: wrong-path branch right after a mispredict has no effect
        drive_br(32'hC0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300);
        exp_q.push_back(32'h300);
        step();
        check_redirect("sq1");
        drive_br(32'hC0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200);
        check("sq_br", {31'd0, Branch_out}, 32'd0);
        step();
        drive_idle();
        check("sq_mp", {31'd0, Mispredict}, 32'd0);
        check("sq_bht48", {30'd0, dut.bht[48]}, 32'd2);
        check("sq_rpc", Redirect_PC, 32'h300);

        // Op 4 and invalid ops
        drive_br(32'h104, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 32'h500);
        check("bltz_br", {31'd0, Branch_out}, 32'd1);
        step();
        check("bltz_mp", {31'd0, Mispredict}, 32'd0);
        check("bltz_bht1", {30'd0, dut.bht[1]}, 32'd2);
        drive_br(32'h108, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h500);
        check("bgez_br", {31'd0, Branch_out}, 32'd0);
        step();
        check("bgez_bht2", {30'd0, dut.bht[2]}, 32'd0);
        drive_br(32'h10C, 3'd6, 1'b0, 1'b1, 1'b1, 1'b1, 32'h500);
        check("op6_br", {31'd0, Branch_out}, 32'd0);
        step();
        check("op6_mp", {31'd0, Mispredict}, 32'd0);
        check("op6_bht3", {30'd0, dut.bht[3]}, 32'd1);

        // Remaining condition encodings, predicted correctly so no redirects
        for (int i = 0; i < 6; i++) begin
            drive_br(32'h200 + 32'(i * 4), vecs[i].op, vecs[i].rt, vecs[i].z, vecs[i].s,
                     vecs[i].exp, 32'h600);
            check($sformatf("cond%0d_br", i), {31'd0, Branch_out}, {31'd0, vecs[i].exp});
            step();
            check($sformatf("cond%0d_mp", i), {31'd0, Mispredict}, 32'd0);
        end

        // Reset asserted during SQUASH with Mispredict high
        drive_br(32'h144, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400);
        exp_q.push_back(32'h400);
        step();
        drive_idle();
        check_redirect("mid");
        check("mid_state", {31'd0, Dbg_State}, 32'd1);
        #2 Rst_n = 1'b0;
        #1;
        check("mid_mp", {31'd0, Mispredict}, 32'd0);
        check("mid_rpc", Redirect_PC, 32'd0);
        check("mid_state_rst", {31'd0, Dbg_State}, 32'd0);
        check("mid_bht17", {30'd0, dut.bht[17]}, 32'd1);
        check("mid_bht32", {30'd0, dut.bht[32]}, 32'd1);
        step();
        Rst_n = 1'b1;
        step();

`ifdef BRANCH_STATS_EN
        check("st_rst_br", Stat_Branches, 32'd0);
        drive_br(32'h40, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
        step();
        drive_idle();
        check("st_br", Stat_Branches, 32'd1);
        check("st_mp", Stat_Mispredicts, 32'd1);
        step();
`endif

        check("q_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
